alu_decode_stage: RTL and testbench

- Instruction-decode pipeline stage on the producer side of the ALU control interface.
- Takes a fetched RV32I instruction and PC, and decodes them into the ALU opcode, branch-compare select, immediate and operand selects the execute stage consumes.
- Holds one registered slot with a valid/ready handshake, stall back-pressure and flush.
- Sits between the fetch stage and the execute stage.

---
 rtl/core_pkg.sv | 105 ++++++++++
 rtl/imm_gen.sv | 37 +++
 rtl/alu_decode_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//
// Shared definitions for the decode stage and its consumers:
//   - alu_op_e   : ALU opcode driven to the execute stage
//   - br_cmp_e   : branch-compare select driven to the execute stage
//   - imm_fmt_e  : immediate format chosen by decode, consumed by imm_gen
//   - OPC_*      : RV32I major opcodes recognised by decode
//   - decoded_t  : the decoded bundle held in the stage register
//   - alu_from_funct3 / branch_cmp_from_funct3 : funct3 lookup helpers
// ----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SCOMP = 4'b1000,
        ALU_LUI   = 4'b1001,
        ALU_SLL   = 4'b1010,
        ALU_SRL   = 4'b1011,
        ALU_SRA   = 4'b1100,
        ALU_AND   = 4'b1101,
        ALU_OR    = 4'b1110,
        ALU_XOR   = 4'b1111
    } alu_op_e;

    // 2'b10 is unused; LT doubles as the "don't care" value for non-branches.
    typedef enum logic [1:0] {
        BR_LT  = 2'b00,
        BR_EQ  = 2'b01,
        BR_LTU = 2'b11
    } br_cmp_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_control;
        br_cmp_e     branch_control;
        logic        branch_inv;
        logic        is_branch;
        logic        is_jump;
        logic [31:0] imm;
        logic        src_a_pc;
        logic        src_b_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } decoded_t;

    // Register-register / register-immediate ALU op from funct3.
    // use_sub selects SUB for funct3=000, use_sra selects SRA for funct3=101.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       use_sub,
                                                input logic       use_sra);
        alu_op_e op;
        case (funct3)
            3'b000:  op = use_sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SCOMP;
            3'b011:  op = ALU_SCOMP;
            3'b100:  op = ALU_XOR;
            3'b101:  op = use_sra ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch funct3[2:1] picks the comparison; funct3[0] is the inversion.
    function automatic br_cmp_e branch_cmp_from_funct3(input logic [2:0] funct3);
        br_cmp_e cmp;
        case (funct3[2:1])
            2'b10:   cmp = BR_LT;
            2'b11:   cmp = BR_LTU;
            default: cmp = BR_EQ;
        endcase
        return cmp;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// ----------------------------------------------------------------------------
// imm_gen
//
// Purely combinational immediate extraction for RV32I. The decode logic picks
// the format; this block only rearranges and sign-extends instruction bits.
// B and J immediates always have bit 0 clear. The opcode field [6:0] never
// contributes to an immediate, so only bits [31:7] are brought in.
//
// Ports:
//   instr  in   instruction bits [31:7]
//   fmt    in   immediate format (IMM_NONE yields zero)
//   imm    out  32-bit immediate
// ----------------------------------------------------------------------------
module imm_gen
    import core_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: every path assigns imm (default arm included), so no latch is inferred.
        case (fmt)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'h000};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'd0, instr[24:20]};
            default:   imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ----------------------------------------------------------------------------
// alu_decode_stage
//
// RV32I instruction-decode stage between fetch and execute. Decodes the
// incoming instruction combinationally and holds the result in a single
// registered slot with a valid/ready handshake; flush kills both the held
// bundle and any instruction offered in the same cycle.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   in_valid/in_ready         fetch-side handshake (in_ready is combinational)
//   in_instr, in_pc           instruction word and its PC
//   flush                     branch redirect: drop held and incoming work
//   out_valid/out_ready       execute-side handshake
//   out_pc                    registered PC
//   out_alu_control           ALU opcode (core_pkg::alu_op_e)
//   out_branch_control        compare select (core_pkg::br_cmp_e)
//   out_branch_inv            invert compare result
//   out_is_branch/out_is_jump conditional branch / jal,jalr
//   out_imm                   sign-extended immediate
//   out_src_a_pc/out_src_b_imm operand selects
//   out_rs1/out_rs2/out_rd    register indices
//   out_reg_write             writes rd (never for rd==x0)
//   out_mem_read/out_mem_write load / store
//   out_illegal               unsupported opcode / funct
// ----------------------------------------------------------------------------
module alu_decode_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_control,
    output logic [1:0]      out_branch_control,
    output logic            out_branch_inv,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic [31:0]     out_imm,
    output logic            out_src_a_pc,
    output logic            out_src_b_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_fmt_e    imm_fmt;
    logic [31:0] imm;
    logic        writes_rd;
    logic        is_shift;
    decoded_t    dec;

    decoded_t        held;
    logic [XLEN-1:0] held_pc;
    logic            held_valid;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    // ------------------------------------------------------------------
    // Combinational decode of the instruction currently offered by fetch.
    // ------------------------------------------------------------------
    always_comb begin
        dec                = '0;
        dec.alu_control    = ALU_ADD;
        dec.branch_control = BR_LT;
        dec.rs1            = in_instr[19:15];
        dec.rs2            = in_instr[24:20];
        dec.rd             = in_instr[11:7];
        imm_fmt            = IMM_NONE;
        writes_rd          = 1'b0;

        case (opcode)
            OPC_LUI: begin
                dec.alu_control = ALU_LUI;
                dec.src_b_imm   = 1'b1;
                imm_fmt         = IMM_U;
                writes_rd       = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                imm_fmt       = IMM_U;
                writes_rd     = 1'b1;
            end
            OPC_JAL: begin
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.is_jump   = 1'b1;
                imm_fmt       = IMM_J;
                writes_rd     = 1'b1;
            end
            OPC_JALR: begin
                dec.src_b_imm = 1'b1;
                dec.is_jump   = 1'b1;
                imm_fmt       = IMM_I;
                writes_rd     = 1'b1;
            end
            OPC_BRANCH: begin
                // Operands are rs1/rs2 for the compare; the immediate is the offset.
                dec.is_branch      = 1'b1;
                dec.branch_control = branch_cmp_from_funct3(funct3);
                dec.branch_inv     = funct3[0];
                imm_fmt            = IMM_B;
            end
            OPC_LOAD: begin
                dec.src_b_imm = 1'b1;
                dec.mem_read  = 1'b1;
                imm_fmt       = IMM_I;
                writes_rd     = 1'b1;
            end
            OPC_STORE: begin
                dec.src_b_imm = 1'b1;
                dec.mem_write = 1'b1;
                imm_fmt       = IMM_S;
            end
            OPC_OP_IMM: begin
                // No SUB form here: funct7[5] only matters for srai.
                dec.alu_control    = alu_from_funct3(funct3, 1'b0, funct7[5]);
                dec.branch_control = (funct3 == 3'b011) ? BR_LTU : BR_LT;
                dec.src_b_imm      = 1'b1;
                writes_rd          = 1'b1;
                if (is_shift) begin
                    imm_fmt = IMM_SHAMT;
                    // slli needs funct7=0; srli/srai may also use 0100000.
                    if (funct3 == 3'b001)
                        dec.illegal = (funct7 != FUNCT7_BASE);
                    else
                        dec.illegal = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                end else begin
                    imm_fmt = IMM_I;
                end
            end
            OPC_OP: begin
                dec.alu_control    = alu_from_funct3(funct3, funct7[5], funct7[5]);
                dec.branch_control = (funct3 == 3'b011) ? BR_LTU : BR_LT;
                dec.illegal        = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                writes_rd          = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        // An illegal bundle still flows downstream, but must have no side
        // effects: only the raw register indices and immediate survive.
        if (dec.illegal) begin
            dec.alu_control    = ALU_ADD;
            dec.branch_control = BR_LT;
            dec.branch_inv     = 1'b0;
            dec.is_branch      = 1'b0;
            dec.is_jump        = 1'b0;
            dec.src_a_pc       = 1'b0;
            dec.src_b_imm      = 1'b0;
            dec.mem_read       = 1'b0;
            dec.mem_write      = 1'b0;
            writes_rd          = 1'b0;
        end

        dec.reg_write = writes_rd && (dec.rd != 5'd0);
        dec.imm       = imm;
    end

    // ------------------------------------------------------------------
    // Handshake slot. Priority: reset, flush, accept, drain, hold.
    // ------------------------------------------------------------------
    assign in_ready = !held_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the whole bundle is cleared on reset, not just valid, so the
            // execute stage never observes leftover fields after reset.
            held_valid <= 1'b0;
            held       <= '0;
            held_pc    <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            held_valid <= 1'b1;
            held       <= dec;
            held_pc    <= in_pc;
        end else if (out_ready) begin
            held_valid <= 1'b0;
        end
    end

    assign out_valid          = held_valid;
    assign out_pc             = held_pc;
    assign out_alu_control    = held.alu_control;
    assign out_branch_control = held.branch_control;
    assign out_branch_inv     = held.branch_inv;
    assign out_is_branch      = held.is_branch;
    assign out_is_jump        = held.is_jump;
    assign out_imm            = held.imm;
    assign out_src_a_pc       = held.src_a_pc;
    assign out_src_b_imm      = held.src_b_imm;
    assign out_rs1            = held.rs1;
    assign out_rs2            = held.rs2;
    assign out_rd             = held.rd;
    assign out_reg_write      = held.reg_write;
    assign out_mem_read       = held.mem_read;
    assign out_mem_write      = held.mem_write;
    assign out_illegal        = held.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Directed steps followed by randomized traffic for alu_decode_stage. The
// expected bundle comes from a mnemonic-level RV32I model with arithmetic
// immediates, and a one-slot handshake model tracks expected out_valid.
// ----------------------------------------------------------------------------
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_alu_control;
    logic [1:0]  out_branch_control;
    logic        out_branch_inv;
    logic        out_is_branch;
    logic        out_is_jump;
    logic [31:0] out_imm;
    logic        out_src_a_pc;
    logic        out_src_b_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_illegal;

    alu_decode_stage #(.XLEN(32)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_instr           (in_instr),
        .in_pc              (in_pc),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_pc             (out_pc),
        .out_alu_control    (out_alu_control),
        .out_branch_control (out_branch_control),
        .out_branch_inv     (out_branch_inv),
        .out_is_branch      (out_is_branch),
        .out_is_jump        (out_is_jump),
        .out_imm            (out_imm),
        .out_src_a_pc       (out_src_a_pc),
        .out_src_b_imm      (out_src_b_imm),
        .out_rs1            (out_rs1),
        .out_rs2            (out_rs2),
        .out_rd             (out_rd),
        .out_reg_write      (out_reg_write),
        .out_mem_read       (out_mem_read),
        .out_mem_write      (out_mem_write),
        .out_illegal        (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [1:0]  bc;
        logic        inv;
        logic        br;
        logic        jmp;
        logic [31:0] imm;
        logic        apc;
        logic        bimm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_valid  = 1'b0;
    exp_t m_exp    = '0;

    // Reinterpret an unsigned field value of the given width as two's complement.
    function automatic logic [31:0] sext(input int v, input int bits);
        int r;
        r = v;
        if (r >= (1 << (bits - 1)))
            r = r - (1 << bits);
        return 32'(r);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       writes;
        logic [3:0] alu_tab [8];
        alu_tab = '{4'b0000, 4'b1010, 4'b1000, 4'b1000, 4'b1111, 4'b1011, 4'b1110, 4'b1101};
        e      = '0;
        op     = w[6:0];
        f3     = w[14:12];
        f7     = w[31:25];
        writes = 1'b0;
        e.pc   = pc;
        e.rs1  = w[19:15];
        e.rs2  = w[24:20];
        e.rd   = w[11:7];
        case (op)
            7'b0110111: begin // lui
                e.alu = 4'b1001; e.imm = w & 32'hFFFF_F000; e.bimm = 1'b1; writes = 1'b1;
            end
            7'b0010111: begin // auipc
                e.imm = w & 32'hFFFF_F000; e.apc = 1'b1; e.bimm = 1'b1; writes = 1'b1;
            end
            7'b1101111: begin // jal
                e.imm = sext(int'(w[31]) * 1048576 + int'(w[19:12]) * 4096
                             + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
                e.apc = 1'b1; e.bimm = 1'b1; e.jmp = 1'b1; writes = 1'b1;
            end
            7'b1100111: begin // jalr
                e.imm = sext(int'(w[31:20]), 12); e.bimm = 1'b1; e.jmp = 1'b1; writes = 1'b1;
            end
            7'b1100011: begin // beq bne blt bge bltu bgeu
                e.br  = 1'b1;
                e.imm = sext(int'(w[31]) * 4096 + int'(w[7]) * 2048
                             + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
                case (f3)
                    3'd0:    begin e.bc = 2'b01; e.inv = 1'b0; end
                    3'd1:    begin e.bc = 2'b01; e.inv = 1'b1; end
                    3'd4:    begin e.bc = 2'b00; e.inv = 1'b0; end
                    3'd5:    begin e.bc = 2'b00; e.inv = 1'b1; end
                    3'd6:    begin e.bc = 2'b11; e.inv = 1'b0; end
                    default: begin e.bc = 2'b11; e.inv = 1'b1; end
                endcase
            end
            7'b0000011: begin // loads
                e.imm = sext(int'(w[31:20]), 12); e.bimm = 1'b1; e.mr = 1'b1; writes = 1'b1;
            end
            7'b0100011: begin // stores
                e.imm = sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12); e.bimm = 1'b1; e.mw = 1'b1;
            end
            7'b0010011: begin // OP-IMM
                e.alu = alu_tab[f3]; e.bimm = 1'b1; writes = 1'b1;
                e.bc  = (f3 == 3'd3) ? 2'b11 : 2'b00;
                if (f3 == 3'd1) begin
                    e.imm = {27'd0, w[24:20]};
                    e.ill = (f7 != 7'd0);
                end else if (f3 == 3'd5) begin
                    e.imm = {27'd0, w[24:20]};
                    if (f7 == 7'b0100000) e.alu = 4'b1100;
                    else if (f7 != 7'd0)  e.ill = 1'b1;
                end else begin
                    e.imm = sext(int'(w[31:20]), 12);
                end
            end
            7'b0110011: begin // OP
                e.alu = alu_tab[f3]; writes = 1'b1;
                e.bc  = (f3 == 3'd3) ? 2'b11 : 2'b00;
                if (f7 != 7'd0 && f7 != 7'b0100000) e.ill = 1'b1;
                else if (f7 == 7'b0100000 && f3 == 3'd0) e.alu = 4'b0001;
                else if (f7 == 7'b0100000 && f3 == 3'd5) e.alu = 4'b1100;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.alu = 4'b0000; e.bc = 2'b00; e.inv = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
            e.apc = 1'b0; e.bimm = 1'b0; e.mr = 1'b0; e.mw = 1'b0; writes = 1'b0;
        end
        e.rw = writes && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [2:0]  br_f3   [6];
        logic [6:0]  bad_ops [5];
        br_f3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        bad_ops = '{7'h7F, 7'h0F, 7'h73, 7'h00, 7'h5B};
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;
            4: begin w[6:0] = 7'b1100011; w[14:12] = br_f3[$urandom_range(0, 5)]; end
            5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;
            7: begin
                w[6:0] = 7'b0010011;
                if (w[13:12] == 2'b01 && $urandom_range(0, 3) != 0)
                    w[31:25] = (w[14] && w[30]) ? 7'b0100000 : 7'b0000000;
            end
            8: begin
                w[6:0] = 7'b0110011;
                if ($urandom_range(0, 3) != 0)
                    w[31:25] = w[30] ? 7'b0100000 : 7'b0000000;
            end
            default: w[6:0] = bad_ops[$urandom_range(0, 4)];
        endcase
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".in_ready"},  32'(in_ready),  32'(!m_valid || out_ready));
        if (m_valid) begin
            check({tag, ".pc"},    out_pc,                     m_exp.pc);
            check({tag, ".alu"},   32'(out_alu_control),       32'(m_exp.alu));
            check({tag, ".bc"},    32'(out_branch_control),    32'(m_exp.bc));
            check({tag, ".inv"},   32'(out_branch_inv),        32'(m_exp.inv));
            check({tag, ".br"},    32'(out_is_branch),         32'(m_exp.br));
            check({tag, ".jmp"},   32'(out_is_jump),           32'(m_exp.jmp));
            check({tag, ".imm"},   out_imm,                    m_exp.imm);
            check({tag, ".apc"},   32'(out_src_a_pc),          32'(m_exp.apc));
            check({tag, ".bimm"},  32'(out_src_b_imm),         32'(m_exp.bimm));
            check({tag, ".rs1"},   32'(out_rs1),               32'(m_exp.rs1));
            check({tag, ".rs2"},   32'(out_rs2),               32'(m_exp.rs2));
            check({tag, ".rd"},    32'(out_rd),                32'(m_exp.rd));
            check({tag, ".rw"},    32'(out_reg_write),         32'(m_exp.rw));
            check({tag, ".mr"},    32'(out_mem_read),          32'(m_exp.mr));
            check({tag, ".mw"},    32'(out_mem_write),         32'(m_exp.mw));
            check({tag, ".ill"},   32'(out_illegal),           32'(m_exp.ill));
        end
    endtask

    // Advance the handshake model with the inputs now applied, then step the
    // clock and settle 1 time unit past the edge before anything is sampled.
    task automatic tick();
        logic acc_ready;
        acc_ready = !m_valid || out_ready;
        if (!rstn) begin
            m_valid = 1'b0;
            m_exp   = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && acc_ready) begin
            m_valid = 1'b1;
            m_exp   = ref_decode(in_instr, in_pc);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.alu",       32'(out_alu_control), 32'd0);
        check("rst.imm",       out_imm, 32'd0);
        check("rst.pc",        out_pc, 32'd0);
        check("rst.rw",        32'(out_reg_write), 32'd0);
        check("rst.in_ready",  32'(in_ready), 32'd1);
        rstn = 1'b1;

        // addi x1,x0,5
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h0000_0100;
        tick();
        check_all("addi");
        check("addi.imm_lit", out_imm, 32'd5);
        check("addi.alu_lit", 32'(out_alu_control), 32'h0);
        check("addi.rd_lit",  32'(out_rd), 32'd1);

        // sub x3,x1,x2
        in_instr = 32'h4020_81B3; in_pc = 32'h0000_0104;
        tick();
        check_all("sub");
        check("sub.alu_lit", 32'(out_alu_control), 32'h1);

        // bne x1,x2,+8
        in_instr = 32'h0020_9463; in_pc = 32'h0000_0108;
        tick();
        check_all("bne");
        check("bne.imm_lit", out_imm, 32'd8);
        check("bne.bc_lit",  32'(out_branch_control), 32'h1);
        check("bne.inv_lit", 32'(out_branch_inv), 32'd1);

        // sltiu x6,x1,-1
        in_instr = 32'hFFF0_B313; in_pc = 32'h0000_010C;
        tick();
        check_all("sltiu");
        check("sltiu.imm_lit", out_imm, 32'hFFFF_FFFF);
        check("sltiu.bc_lit",  32'(out_branch_control), 32'h3);

        // lui accepted, then back-pressure for 3 cycles with another offer waiting
        in_instr = 32'h1234_52B7; in_pc = 32'h0000_0110;
        tick();
        check_all("lui");
        out_ready = 1'b0;
        in_instr  = 32'h0050_0093; in_pc = 32'h0000_0114;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall");
            check("stall.in_ready", 32'(in_ready), 32'd0);
            check("stall.alu_lit",  32'(out_alu_control), 32'h9);
            check("stall.imm_lit",  out_imm, 32'h1234_5000);
        end

        // flush while an instruction is offered and could be accepted
        out_ready = 1'b1; flush = 1'b1;
        tick();
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check_all("flush");
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush.dropped", 32'(out_valid), 32'd0);

        // unknown opcode flows as illegal, then reset during the hold
        in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 32'h0000_0200; out_ready = 1'b0;
        tick();
        check_all("illegal");
        check("illegal.ill_lit", 32'(out_illegal), 32'd1);
        check("illegal.rw_lit",  32'(out_reg_write), 32'd0);
        in_valid = 1'b0;
        tick();
        check_all("illegal_hold");
        rstn = 1'b0;
        tick();
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.ill",       32'(out_illegal), 32'd0);
        rstn = 1'b1; out_ready = 1'b1;
        tick();
        check_all("post_rst");

        // randomized traffic with back-pressure, flushes and rare resets
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rstn      = ($urandom_range(0, 99) != 0);
            tick();
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
